// File: rtl/fanout_if.sv
// fanout_if: upstream ready/valid stream plus its per-consumer broadcast side.
interface fanout_if #(
    parameter int NUM_OUT = 7,
    parameter int DATA_W  = 16
);
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/fanout_broadcast.sv
// fanout_broadcast: registered eager fork; retires an item once every routed port has taken it.
module fanout_broadcast #(
    parameter int NUM_OUT = 7,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fanout_if.slave            bus,
    input  logic [NUM_OUT-1:0] cfg_enable,
    input  logic [NUM_OUT-1:0] cfg_sel,
    output logic [CNT_W-1:0]   retired_cnt
);
    logic               full_q, full_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [NUM_OUT-1:0] mask_q, mask_d;
    logic [NUM_OUT-1:0] done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0] acc;
    logic               complete, load;

    // done_q hides ports that already took the item, so a ready toggle never re-delivers
    assign bus.out_valid = {NUM_OUT{full_q}} & mask_q & ~done_q;
    assign bus.out_data  = data_q;
    assign acc           = bus.out_valid & bus.out_ready;
    assign complete      = full_q & (&(~mask_q | done_q | acc));
    assign bus.in_ready  = ~full_q | complete;
    assign load          = bus.in_valid & bus.in_ready;
    assign retired_cnt   = cnt_q;

    always_comb begin
        full_d = load ? 1'b1 : (complete ? 1'b0 : full_q);
        data_d = load ? bus.in_data : data_q;
        mask_d = load ? (cfg_enable & cfg_sel) : mask_q;
        done_d = (load | complete) ? '0 : (full_q ? (done_q | acc) : done_q);
        cnt_d  = cnt_q + CNT_W'(complete);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            mask_q <= '0;
            done_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            mask_q <= mask_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fanout_broadcast.sv
// tb_fanout_broadcast: directed vectors, literal checks and a per-cycle model comparison.
module tb_fanout_broadcast;
    localparam int N = 7;
    localparam int W = 16;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] cfg_enable = '0;
    logic [N-1:0] cfg_sel = '0;
    logic [C-1:0] retired_cnt;
    int           checks = 0;
    int           failures = 0;

    fanout_if #(.NUM_OUT(N), .DATA_W(W)) bus ();

    fanout_broadcast #(.NUM_OUT(N), .DATA_W(W), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cfg_enable(cfg_enable), .cfg_sel(cfg_sel), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Model: an item is held together with the set of ports still owed a copy.
    logic         m_full;
    logic [W-1:0] m_data;
    logic [N-1:0] m_owed;
    logic [C-1:0] m_cnt;
    logic         m_fin;
    assign m_fin = m_full && ((m_owed & ~bus.out_ready) == '0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 1'b0;
            m_data <= '0;
            m_owed <= '0;
            m_cnt  <= '0;
        end else begin
            if (m_fin) m_cnt <= m_cnt + 1'b1;
            if (bus.in_valid && (!m_full || m_fin)) begin
                m_full <= 1'b1;
                m_data <= bus.in_data;
                m_owed <= cfg_enable & cfg_sel;
            end else if (m_fin) m_full <= 1'b0;
            else m_owed <= m_owed & ~bus.out_ready;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_out_valid", 64'(bus.out_valid), 64'(m_full ? m_owed : '0));
            chk("model_in_ready", 64'(bus.in_ready), 64'(!m_full || m_fin));
            chk("model_retired", 64'(retired_cnt), 64'(m_cnt));
            if (m_full) chk("model_out_data", 64'(bus.out_data), 64'(m_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        #2;
        chk("reset_out_valid", 64'(bus.out_valid), 64'h0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'h1);
        chk("reset_retired", 64'(retired_cnt), 64'h0);
        chk("reset_out_data", 64'(bus.out_data), 64'h0);
        do_reset();

        // back-to-back stream to ports 0 and 1
        cfg_enable = 7'h7F;
        cfg_sel = 7'h03;
        bus.out_ready = 7'h7F;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'(i);
            step();
            chk("stream_valid", 64'(bus.out_valid), 64'h03);
            chk("stream_data", 64'(bus.out_data), 64'(i));
            chk("stream_in_ready", 64'(bus.in_ready), 64'h1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_idle_valid", 64'(bus.out_valid), 64'h0);
        chk("stream_retired", 64'(retired_cnt), 64'h4);

        // skewed acceptance: ports 0, 2, 1 on successive cycles
        cfg_sel = 7'h07;
        bus.out_ready = '0;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hABCD;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 7'h01;
        #1;
        chk("skew_c1_valid", 64'(bus.out_valid), 64'h07);
        chk("skew_c1_in_ready", 64'(bus.in_ready), 64'h0);
        step();
        bus.out_ready = 7'h05;
        #1;
        chk("skew_c2_valid", 64'(bus.out_valid), 64'h06);
        chk("skew_c2_in_ready", 64'(bus.in_ready), 64'h0);
        step();
        bus.out_ready = 7'h03;
        #1;
        chk("skew_c3_valid", 64'(bus.out_valid), 64'h02);
        chk("skew_c3_in_ready", 64'(bus.in_ready), 64'h1);
        step();
        chk("skew_done_valid", 64'(bus.out_valid), 64'h0);
        chk("skew_retired", 64'(retired_cnt), 64'h5);

        // configuration change while an item is held
        bus.out_ready = '0;
        cfg_sel = 7'h01;
        bus.in_valid = 1'b1;
        bus.in_data = 16'h1111;
        step();
        cfg_sel = 7'h03;
        bus.in_data = 16'h2222;
        step();
        chk("cfg_held_valid", 64'(bus.out_valid), 64'h01);
        chk("cfg_held_data", 64'(bus.out_data), 64'h1111);
        bus.out_ready = 7'h01;
        step();
        bus.in_valid = 1'b0;
        chk("cfg_next_valid", 64'(bus.out_valid), 64'h03);
        chk("cfg_next_data", 64'(bus.out_data), 64'h2222);
        bus.out_ready = 7'h7F;
        step();
        chk("cfg_retired", 64'(retired_cnt), 64'h7);

        // zero mask: items retire silently
        cfg_enable = '0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'h0100 + 16'(i);
            step();
            chk("zero_valid", 64'(bus.out_valid), 64'h0);
            chk("zero_in_ready", 64'(bus.in_ready), 64'h1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("zero_retired", 64'(retired_cnt), 64'hA);

        // reset with port 0 done and port 1 pending
        cfg_enable = 7'h7F;
        cfg_sel = 7'h03;
        bus.out_ready = '0;
        bus.in_valid = 1'b1;
        bus.in_data = 16'h5555;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 7'h01;
        step();
        bus.out_ready = '0;
        chk("rst_pre_valid", 64'(bus.out_valid), 64'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
        chk("rst_retired", 64'(retired_cnt), 64'h0);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 16'h6666;
        step();
        bus.in_valid = 1'b0;
        chk("rst_next_valid", 64'(bus.out_valid), 64'h03);
        chk("rst_next_data", 64'(bus.out_data), 64'h6666);
        bus.out_ready = 7'h7F;
        step();
        chk("rst_next_retired", 64'(retired_cnt), 64'h1);

        // 16 retirements wrap the 4-bit counter back to zero
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'h0200 + 16'(i);
            step();
            if (i == 15) chk("wrap_retired_15", 64'(retired_cnt), 64'hF);
        end
        bus.in_valid = 1'b0;
        step();
        chk("wrap_retired_0", 64'(retired_cnt), 64'h0);
        chk("wrap_idle_valid", 64'(bus.out_valid), 64'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
